// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and widths for the VRAM arbiter
package vram_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {IDLE, GFX_BUSY, DISP_BUSY} state_t;
    typedef enum logic {OWN_GFX, OWN_DISP} owner_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: rasterizer, scanout, memory and buffer-status signals of the VRAM arbiter
interface vram_arbiter_if;
    import vram_arb_pkg::*;
    logic              gfx_sel_i;
    logic              gfx_wr_i;
    logic [MASK_W-1:0] gfx_mask_i;
    logic [ADDR_W-1:0] gfx_addr_i;
    logic [DATA_W-1:0] gfx_data_i;
    logic [DATA_W-1:0] gfx_data_o;
    logic              gfx_ack_o;
    logic              gfx_swap_i;
    logic              disp_sel_i;
    logic [ADDR_W-1:0] disp_addr_i;
    logic [DATA_W-1:0] disp_data_o;
    logic              disp_ack_o;
    logic              disp_vsync_i;
    logic              mem_sel_o;
    logic              mem_wr_o;
    logic [MASK_W-1:0] mem_mask_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic              front_sel_o;
    logic              swap_pending_o;

    modport slave (
        input  gfx_sel_i, gfx_wr_i, gfx_mask_i, gfx_addr_i, gfx_data_i, gfx_swap_i,
        input  disp_sel_i, disp_addr_i, disp_vsync_i, mem_data_i, mem_ack_i,
        output gfx_data_o, gfx_ack_o, disp_data_o, disp_ack_o,
        output mem_sel_o, mem_wr_o, mem_mask_o, mem_addr_o, mem_data_o,
        output front_sel_o, swap_pending_o
    );

    modport master (
        output gfx_sel_i, gfx_wr_i, gfx_mask_i, gfx_addr_i, gfx_data_i, gfx_swap_i,
        output disp_sel_i, disp_addr_i, disp_vsync_i, mem_data_i, mem_ack_i,
        input  gfx_data_o, gfx_ack_o, disp_data_o, disp_ack_o,
        input  mem_sel_o, mem_wr_o, mem_mask_o, mem_addr_o, mem_data_o,
        input  front_sel_o, swap_pending_o
    );
endinterface

// File: rtl/vram_swap_ctrl.sv
// vram_swap_ctrl: defers framebuffer swap requests to the next vsync
module vram_swap_ctrl (
    input  logic clk,
    input  logic reset_i,
    input  logic gfx_swap_i,
    input  logic disp_vsync_i,
    output logic front_sel_o,
    output logic swap_pending_o
);
    logic front_q, front_d, pend_q, pend_d, apply;

    // a swap (pending or arriving now) takes effect on vsync; otherwise it is latched
    always_comb begin
        apply   = disp_vsync_i & (pend_q | gfx_swap_i);
        front_d = front_q ^ apply;
        pend_d  = ~apply & (pend_q | gfx_swap_i);
    end

    // front buffer select and pending flag
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            front_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            front_q <= front_d;
            pend_q  <= pend_d;
        end
    end

    assign front_sel_o    = front_q;
    assign swap_pending_o = pend_q;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: arbitrates rasterizer and scanout onto one double-buffered VRAM port (VRAM_ARB_RR_EN selects round-robin grant)
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 256,
    parameter int unsigned FB_HEIGHT = 256,
    parameter int unsigned BUF0_BASE = 0,
    parameter int unsigned BUF1_BASE = FB_WIDTH * FB_HEIGHT
) (
    input logic           clk,
    input logic           reset_i,
    vram_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] B0 = ADDR_W'(BUF0_BASE);
    localparam logic [ADDR_W-1:0] B1 = ADDR_W'(BUF1_BASE);

    state_t            state_q;
    logic              mem_sel_q, mem_wr_q;
    logic [MASK_W-1:0] mem_mask_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              front_sel, swap_pending, gfx_ok, pick_disp;
    logic [ADDR_W-1:0] gfx_base, disp_base;

    vram_swap_ctrl u_swap (
        .clk            (clk),
        .reset_i        (reset_i),
        .gfx_swap_i     (bus.gfx_swap_i),
        .disp_vsync_i   (bus.disp_vsync_i),
        .front_sel_o    (front_sel),
        .swap_pending_o (swap_pending)
    );

    // gfx stalls while a swap is pending so it never draws into the buffer about to be shown
    assign gfx_ok    = bus.gfx_sel_i & ~swap_pending;
    assign gfx_base  = front_sel ? B0 : B1;
    assign disp_base = front_sel ? B1 : B0;

`ifdef VRAM_ARB_RR_EN
    owner_t owner_q;

    assign pick_disp = bus.disp_sel_i & (~gfx_ok | (owner_q == OWN_GFX));

    // remember the last grantee so the other side wins the next tie
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i)
            owner_q <= OWN_GFX;
        else if (state_q == IDLE && (pick_disp || gfx_ok))
            owner_q <= pick_disp ? OWN_DISP : OWN_GFX;
    end
`else
    assign pick_disp = bus.disp_sel_i;
`endif

    assign bus.gfx_ack_o      = (state_q == GFX_BUSY) & bus.mem_ack_i;
    assign bus.disp_ack_o     = (state_q == DISP_BUSY) & bus.mem_ack_i;
    assign bus.gfx_data_o     = bus.mem_data_i;
    assign bus.disp_data_o    = bus.mem_data_i;
    assign bus.mem_sel_o      = mem_sel_q;
    assign bus.mem_wr_o       = mem_wr_q;
    assign bus.mem_mask_o     = mem_mask_q;
    assign bus.mem_addr_o     = mem_addr_q;
    assign bus.mem_data_o     = mem_data_q;
    assign bus.front_sel_o    = front_sel;
    assign bus.swap_pending_o = swap_pending;

    // grant FSM: latch the winner's request with its buffer base, hold it until memory acks
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            mem_sel_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_mask_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else if (state_q == IDLE) begin
            if (pick_disp) begin
                state_q    <= DISP_BUSY;
                mem_sel_q  <= 1'b1;
                mem_wr_q   <= 1'b0;
                mem_mask_q <= '0;
                mem_data_q <= '0;
                mem_addr_q <= disp_base + bus.disp_addr_i;
            end else if (gfx_ok) begin
                state_q    <= GFX_BUSY;
                mem_sel_q  <= 1'b1;
                mem_wr_q   <= bus.gfx_wr_i;
                mem_mask_q <= bus.gfx_mask_i;
                mem_data_q <= bus.gfx_data_i;
                mem_addr_q <= gfx_base + bus.gfx_addr_i;
            end
        end else if (bus.mem_ack_i) begin
            state_q   <= IDLE;
            mem_sel_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a 3-cycle-latency memory model
module tb_vram_arbiter;
    typedef struct packed {
        logic        disp;
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [15:0] data;
    } txn_t;

    localparam logic [31:0] B0 = 32'h0;
    localparam logic [31:0] B1 = 32'h10000;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    vram_arbiter_if bus();

    vram_arbiter dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    txn_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_front = 1'b0;
    logic exp_last_disp = 1'b0;
    logic hold = 1'b0;
    logic first_disp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rdv(input logic [31:0] a);
        return a[15:0] ^ 16'h1214;
    endfunction

    // expected memory transaction, in expected grant order
    task automatic push(input logic d, input logic w, input logic [3:0] m,
                        input logic [31:0] off, input logic [15:0] dat);
        txn_t t;
        t.disp = d;
        t.wr   = d ? 1'b0 : w;
        t.mask = d ? 4'h0 : m;
        t.data = d ? 16'h0 : dat;
        t.addr = off + ((d ^ exp_front) ? B0 : B1);
        sb.push_back(t);
        exp_last_disp = d;
    endtask

    task automatic do_gfx(input logic w, input logic [3:0] m, input logic [31:0] off,
                          input logic [15:0] d, input logic [15:0] rexp);
        int n = 0;
        bus.gfx_sel_i  = 1'b1;
        bus.gfx_wr_i   = w;
        bus.gfx_mask_i = m;
        bus.gfx_addr_i = off;
        bus.gfx_data_i = d;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.gfx_ack_o && n < 100);
        check("gfx_done", n < 100, 1);
        if (!w) check("gfx_rdata", bus.gfx_data_o, rexp);
        bus.gfx_sel_i = 1'b0;
    endtask

    task automatic do_disp(input logic [31:0] off, input logic [15:0] rexp);
        int n = 0;
        bus.disp_sel_i  = 1'b1;
        bus.disp_addr_i = off;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.disp_ack_o && n < 100);
        check("disp_done", n < 100, 1);
        check("disp_rdata", bus.disp_data_o, rexp);
        bus.disp_sel_i = 1'b0;
    endtask

    // memory model: pops the scoreboard on each new request, acks 3 cycles later
    initial begin
        txn_t e;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = 16'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_sel_o && !reset_i) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("mem_addr", bus.mem_addr_o, e.addr);
                    check("mem_wr", bus.mem_wr_o, e.wr);
                    check("mem_mask", bus.mem_mask_o, e.mask);
                    check("mem_data", bus.mem_data_o, e.data);
                    while (hold) @(negedge clk);
                    repeat (3) @(negedge clk);
                    if (bus.mem_sel_o) begin
                        bus.mem_data_i = rdv(e.addr);
                        bus.mem_ack_i  = 1'b1;
                        #1;
                        check("mem_hold", bus.mem_addr_o, e.addr);
                        check("gfx_ack", bus.gfx_ack_o, !e.disp);
                        check("disp_ack", bus.disp_ack_o, e.disp);
                        @(negedge clk);
                        bus.mem_ack_i = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.gfx_sel_i    = 1'b0;
        bus.gfx_wr_i     = 1'b0;
        bus.gfx_mask_i   = 4'h0;
        bus.gfx_addr_i   = 32'h0;
        bus.gfx_data_i   = 16'h0;
        bus.gfx_swap_i   = 1'b0;
        bus.disp_sel_i   = 1'b0;
        bus.disp_addr_i  = 32'h0;
        bus.disp_vsync_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_sel", bus.mem_sel_o, 0);
        check("rst_mem_wr", bus.mem_wr_o, 0);
        check("rst_mem_mask", bus.mem_mask_o, 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        check("rst_mem_data", bus.mem_data_o, 0);
        check("rst_gfx_ack", bus.gfx_ack_o, 0);
        check("rst_disp_ack", bus.disp_ack_o, 0);
        check("rst_front", bus.front_sel_o, 0);
        check("rst_pending", bus.swap_pending_o, 0);
        reset_i = 1'b0;
        @(negedge clk);

        // gfx write into back buffer 1
        push(0, 1, 4'hF, 32'h10, 16'hABCD);
        fork
            do_gfx(1, 4'hF, 32'h10, 16'hABCD, 16'h0);
            begin
                @(negedge clk);
                #1;
                check("grant_lat", bus.mem_sel_o, 1);
            end
        join

        // display read from front buffer 0
        @(negedge clk);
        push(1, 0, 4'h0, 32'h20, 16'h0);
        do_disp(32'h20, 16'h1234);

        // simultaneous requests
        @(negedge clk);
        first_disp = 1'b1;
`ifdef VRAM_ARB_RR_EN
        first_disp = !exp_last_disp;
`endif
        if (first_disp) push(1, 0, 4'h0, 32'h50, 16'h0);
        push(0, 1, 4'h3, 32'h60, 16'hBEEF);
        if (!first_disp) push(1, 0, 4'h0, 32'h50, 16'h0);
        fork
            do_disp(32'h50, rdv(32'h50));
            do_gfx(1, 4'h3, 32'h60, 16'hBEEF, 16'h0);
        join

        // swap pending stalls gfx while display continues
        @(negedge clk);
        bus.gfx_swap_i = 1'b1;
        @(negedge clk);
        bus.gfx_swap_i = 1'b0;
        #1;
        check("pend_set", bus.swap_pending_o, 1);
        check("pend_front", bus.front_sel_o, 0);
        push(1, 0, 4'h0, 32'h40, 16'h0);
        exp_front = 1'b1;
        push(0, 0, 4'h0, 32'h30, 16'h0);
        fork
            do_gfx(0, 4'h0, 32'h30, 16'h0, rdv(32'h30 + B0));
            begin
                repeat (3) @(negedge clk);
                #1;
                check("gfx_stall", bus.mem_sel_o, 0);
                do_disp(32'h40, rdv(32'h40));
                @(negedge clk);
                bus.disp_vsync_i = 1'b1;
                @(negedge clk);
                bus.disp_vsync_i = 1'b0;
                #1;
                check("vsync_front", bus.front_sel_o, 1);
                check("vsync_pend", bus.swap_pending_o, 0);
            end
        join

        // swap and vsync together with nothing pending
        @(negedge clk);
        bus.gfx_swap_i   = 1'b1;
        bus.disp_vsync_i = 1'b1;
        @(negedge clk);
        bus.gfx_swap_i   = 1'b0;
        bus.disp_vsync_i = 1'b0;
        #1;
        check("same_front", bus.front_sel_o, 0);
        check("same_pend", bus.swap_pending_o, 0);
        exp_front = 1'b0;

        // repeated swap while pending toggles only once
        @(negedge clk);
        bus.gfx_swap_i = 1'b1;
        @(negedge clk);
        #1;
        check("dbl_pend", bus.swap_pending_o, 1);
        @(negedge clk);
        bus.gfx_swap_i = 1'b0;
        #1;
        check("dbl_front_hold", bus.front_sel_o, 0);
        check("dbl_pend_hold", bus.swap_pending_o, 1);
        @(negedge clk);
        bus.disp_vsync_i = 1'b1;
        @(negedge clk);
        bus.disp_vsync_i = 1'b0;
        #1;
        check("dbl_front", bus.front_sel_o, 1);
        check("dbl_pend_clr", bus.swap_pending_o, 0);
        exp_front = 1'b1;

        // async reset in the middle of a gfx transaction
        @(negedge clk);
        hold = 1'b1;
        push(0, 1, 4'h5, 32'h70, 16'h7777);
        bus.gfx_sel_i  = 1'b1;
        bus.gfx_wr_i   = 1'b1;
        bus.gfx_mask_i = 4'h5;
        bus.gfx_addr_i = 32'h70;
        bus.gfx_data_i = 16'h7777;
        @(negedge clk);
        #1;
        check("busy_sel", bus.mem_sel_o, 1);
        #2;
        reset_i = 1'b1;
        #1;
        check("rst_async_sel", bus.mem_sel_o, 0);
        check("rst_async_front", bus.front_sel_o, 0);
        bus.gfx_sel_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        hold = 1'b0;
        exp_front = 1'b0;
        exp_last_disp = 1'b0;
        #1;
        check("post_rst_sel", bus.mem_sel_o, 0);
        check("post_rst_front", bus.front_sel_o, 0);
        repeat (6) @(negedge clk);
        push(0, 1, 4'hC, 32'h80, 16'h5555);
        do_gfx(1, 4'hC, 32'h80, 16'h5555, 16'h0);

        repeat (6) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
